// File: rtl/jtgng_romload_pkg.sv
// Shared definitions for the ROM download producer: FSM state encoding and
// the default image size for Ghosts'n Goblins.
package jtgng_romload_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dl_state_t;

    // Complete GnG ROM image, in bytes.
    localparam int unsigned GNG_ROM_SIZE = 32'h0004_8000;

endpackage

// File: rtl/jtgng_romload_fifo.sv
// Small register-based byte FIFO between the host handshake and the
// ROM write engine.
//   clk    : system clock
//   rst_n  : asynchronous active-low clear
//   clr    : synchronous clear (start of a new download)
//   push   : write din (ignored when full)
//   din    : byte in
//   pop    : advance read pointer (ignored when empty)
//   dout   : byte at the head of the FIFO (valid when !empty)
//   full   : DEPTH bytes held
//   empty  : no bytes held
//   level  : current occupancy, 0..DEPTH
module jtgng_romload_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (level == LVL_MAX);
    assign empty   = (level == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/jtgng_romload_tx.sv
// Producer side of the ROM download path. Accepts host bytes over a
// valid/ready handshake, buffers them, and paces them out as ROM loader
// write strobes with sequential addresses from 0.
//   clk, rst_n    : system clock, asynchronous active-low reset
//   dl_start      : pulse, begins a download (IDLE/DONE only)
//   dl_end        : pulse, host end of stream (LOAD only)
//   dl_valid/data : host byte stream
//   dl_ready      : byte accepted when dl_valid & dl_ready
//   romload_wr    : one-cycle write strobe with romload_addr/romload_data
//   downloading   : high from LOAD through DRAIN
//   dl_done       : one-cycle pulse on entry to DONE
//   dl_short      : sticky, image ended before ROM_SIZE bytes
module jtgng_romload_tx
    import jtgng_romload_pkg::*;
#(
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned ROM_SIZE   = GNG_ROM_SIZE,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WR_GAP     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dl_start,
    input  logic              dl_end,
    input  logic              dl_valid,
    input  logic [7:0]        dl_data,
    output logic              dl_ready,
    output logic              romload_wr,
    output logic [ADDR_W-1:0] romload_addr,
    output logic [7:0]        romload_data,
    output logic              downloading,
    output logic              dl_done,
    output logic              dl_short
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned GAP_W = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
    localparam logic [CNT_W-1:0] ROM_LIMIT  = CNT_W'(ROM_SIZE);
    localparam logic [LVL_W-1:0] FIFO_LIMIT = LVL_W'(FIFO_DEPTH);
    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(WR_GAP - 1);

    dl_state_t         state, state_nx;
    logic [CNT_W-1:0]  acc_cnt, acc_nx;
    logic [GAP_W-1:0]  gap_cnt, gap_nx;
    logic [ADDR_W-1:0] wr_addr;
    logic [LVL_W-1:0]  fifo_level, level_nx;
    logic [7:0]        fifo_dout;
    logic              fifo_full, fifo_empty;
    logic              push, pop, start, set_short, ready_nx;

    jtgng_romload_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .push  (push),
        .din   (dl_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // dl_ready is registered, so it is computed from next-cycle occupancy
    // and count to match the combinational !full && acc_cnt < ROM_SIZE rule.
    always_comb begin
        state_nx  = state;
        start     = 1'b0;
        set_short = 1'b0;
        push      = dl_valid && dl_ready;
        pop       = (state == LOAD || state == DRAIN) && !fifo_empty && (gap_cnt == '0);
        acc_nx    = acc_cnt + CNT_W'(push);
        level_nx  = fifo_level + LVL_W'(push) - LVL_W'(pop);

        case (state)
            IDLE, DONE: begin
                if (dl_start) begin
                    state_nx = LOAD;
                    start    = 1'b1;
                end
            end
            LOAD: begin
                if (acc_nx == ROM_LIMIT) begin
                    state_nx = DRAIN;
                end else if (dl_end) begin
                    state_nx  = DRAIN;
                    set_short = 1'b1;
                end
            end
            DRAIN: begin
                if (fifo_empty && gap_cnt == '0) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase

        if (start) begin
            acc_nx   = '0;
            level_nx = '0;
        end

        if (pop)                gap_nx = GAP_LOAD;
        else if (gap_cnt != '0) gap_nx = gap_cnt - 1'b1;
        else                    gap_nx = '0;

        ready_nx = (state_nx == LOAD) && (level_nx < FIFO_LIMIT) && (acc_nx < ROM_LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc_cnt      <= '0;
            gap_cnt      <= '0;
            wr_addr      <= '0;
            dl_ready     <= 1'b0;
            romload_wr   <= 1'b0;
            romload_addr <= '0;
            romload_data <= '0;
            downloading  <= 1'b0;
            dl_done      <= 1'b0;
            dl_short     <= 1'b0;
        end else begin
            state       <= state_nx;
            acc_cnt     <= acc_nx;
            gap_cnt     <= gap_nx;
            wr_addr     <= start ? '0 : wr_addr + ADDR_W'(pop);
            romload_wr  <= pop;
            if (pop) begin
                romload_addr <= wr_addr;
                romload_data <= fifo_dout;
            end
            dl_ready    <= ready_nx;
            downloading <= (state_nx == LOAD) || (state_nx == DRAIN);
            dl_done     <= (state_nx == DONE) && (state != DONE);
            if (start)          dl_short <= 1'b0;
            else if (set_short) dl_short <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jtgng_romload_tx.sv
// Bench for jtgng_romload_tx: two instances with different parameter sets,
// a scoreboard of expected {addr,data} per instance, and strobe timing checks.
module tb_jtgng_romload_tx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: ROM_SIZE=8, FIFO_DEPTH=4, WR_GAP=4
    logic        start_a = 1'b0, end_a = 1'b0, valid_a = 1'b0;
    logic [7:0]  data_a = '0;
    logic        ready_a, wr_a, downloading_a, done_a, short_a;
    logic [18:0] addr_a;
    logic [7:0]  wdata_a;

    // Instance B: ROM_SIZE=16, FIFO_DEPTH=2, WR_GAP=1
    logic        start_b = 1'b0, end_b = 1'b0, valid_b = 1'b0;
    logic [7:0]  data_b = '0;
    logic        ready_b, wr_b, downloading_b, done_b, short_b;
    logic [18:0] addr_b;
    logic [7:0]  wdata_b;

    logic [31:0] outs_a, outs_b;
    assign outs_a = {ready_a, wr_a, downloading_a, done_a, short_a, addr_a, wdata_a};
    assign outs_b = {ready_b, wr_b, downloading_b, done_b, short_b, addr_b, wdata_b};

    jtgng_romload_tx #(
        .ADDR_W(19), .ROM_SIZE(8), .FIFO_DEPTH(4), .WR_GAP(4)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .dl_start(start_a), .dl_end(end_a),
        .dl_valid(valid_a), .dl_data(data_a), .dl_ready(ready_a),
        .romload_wr(wr_a), .romload_addr(addr_a), .romload_data(wdata_a),
        .downloading(downloading_a), .dl_done(done_a), .dl_short(short_a)
    );

    jtgng_romload_tx #(
        .ADDR_W(19), .ROM_SIZE(16), .FIFO_DEPTH(2), .WR_GAP(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .dl_start(start_b), .dl_end(end_b),
        .dl_valid(valid_b), .dl_data(data_b), .dl_ready(ready_b),
        .romload_wr(wr_b), .romload_addr(addr_b), .romload_data(wdata_b),
        .downloading(downloading_b), .dl_done(done_b), .dl_short(short_b)
    );

    int errors = 0;
    int checks = 0;
    logic [26:0] q_a[$];
    logic [26:0] q_b[$];
    logic [18:0] exp_addr_a = '0;
    logic [18:0] exp_addr_b = '0;
    int cyc = 0;
    int nwr_a = 0, nwr_b = 0, ndone_a = 0, ndone_b = 0;
    int last_wr_a = -100, last_wr_b = -100, first_wr_b = 0;
    int done_cyc_a = 0, done_cyc_b = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin : monitor
        logic [26:0] e;
        cyc++;
        if (wr_a) begin
            check("a_wr_expected", 32'(q_a.size() != 0), 1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                check("a_addr", 32'(addr_a), 32'(e[26:8]));
                check("a_data", 32'(wdata_a), 32'(e[7:0]));
            end
            check("a_wr_gap", 32'(cyc - last_wr_a >= 4), 1);
            last_wr_a = cyc;
            nwr_a++;
        end
        if (wr_b) begin
            check("b_wr_expected", 32'(q_b.size() != 0), 1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                check("b_addr", 32'(addr_b), 32'(e[26:8]));
                check("b_data", 32'(wdata_b), 32'(e[7:0]));
            end
            if (nwr_b == 0) first_wr_b = cyc;
            last_wr_b = cyc;
            nwr_b++;
        end
        if (done_a) begin ndone_a++; done_cyc_a = cyc; end
        if (done_b) begin ndone_b++; done_cyc_b = cyc; end
    end

    task automatic pulse_start_a();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0; exp_addr_a = '0;
        check("a_downloading_rise", 32'(downloading_a), 1);
        check("a_short_clr", 32'(short_a), 0);
    endtask

    task automatic pulse_start_b();
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0; exp_addr_b = '0;
        check("b_downloading_rise", 32'(downloading_b), 1);
    endtask

    task automatic pulse_end_a();
        @(negedge clk); end_a = 1'b1;
        @(negedge clk); end_a = 1'b0;
    endtask

    task automatic pulse_end_b();
        @(negedge clk); end_b = 1'b1;
        @(negedge clk); end_b = 1'b0;
    endtask

    // Offer n bytes (holding each until taken) for at most budget cycles;
    // optionally pulse dl_start at cycle poke_at.
    task automatic feed_a(input int n, input logic [7:0] base, input int poke_at,
                          input int budget, output int acc, output int stall);
        int i = 0;
        acc = 0; stall = 0;
        for (int t = 0; t < budget && i < n; t++) begin
            @(negedge clk);
            valid_a = 1'b1;
            data_a  = base + 8'(i);
            start_a = (t == poke_at);
            if (ready_a) begin
                q_a.push_back({exp_addr_a, data_a});
                exp_addr_a++;
                i++; acc++;
            end else begin
                stall++;
            end
        end
        @(negedge clk); valid_a = 1'b0; start_a = 1'b0;
    endtask

    // As feed_a; stops early once stop_wr strobes have been seen (0 = never).
    task automatic feed_b(input int n, input logic [7:0] base, input int stop_wr,
                          input int budget, output int acc, output int stall);
        int i = 0;
        acc = 0; stall = 0;
        for (int t = 0; t < budget && i < n; t++) begin
            if (stop_wr != 0 && nwr_b >= stop_wr) break;
            @(negedge clk);
            valid_b = 1'b1;
            data_b  = base + 8'(i);
            if (ready_b) begin
                q_b.push_back({exp_addr_b, data_b});
                exp_addr_b++;
                i++; acc++;
            end else begin
                stall++;
            end
        end
        @(negedge clk); valid_b = 1'b0;
    endtask

    task automatic wait_done_a(input int budget);
        int t = 0;
        while (!done_a && t < budget) begin @(negedge clk); t++; end
        check("a_done_seen", 32'(done_a), 1);
        check("a_downloading_fall", 32'(downloading_a), 0);
    endtask

    task automatic wait_done_b(input int budget);
        int t = 0;
        while (!done_b && t < budget) begin @(negedge clk); t++; end
        check("b_done_seen", 32'(done_b), 1);
        check("b_downloading_fall", 32'(downloading_b), 0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int acc, stall, n0;

        repeat (3) @(negedge clk);
        check("a_rst_outs", outs_a, 0);
        check("b_rst_outs", outs_b, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // B: WR_GAP=1, depth 2, continuous stream -> one strobe per cycle
        pulse_start_b();
        nwr_b = 0; n0 = ndone_b;
        feed_b(16, 8'h40, 0, 200, acc, stall);
        check("b_acc16", 32'(acc), 16);
        check("b_no_ready_drop", 32'(stall), 0);
        wait_done_b(100);
        repeat (3) @(negedge clk);
        check("b_nwr16", 32'(nwr_b), 16);
        check("b_back_to_back", 32'(last_wr_b - first_wr_b), 15);
        check("b_done_lat", 32'(done_cyc_b - last_wr_b), 1);
        check("b_done_once", 32'(ndone_b - n0), 1);
        check("b_q_empty", 32'(q_b.size()), 0);
        check("b_short_full", 32'(short_b), 0);

        // B: asynchronous reset mid-LOAD after 10 writes
        pulse_start_b();
        nwr_b = 0;
        feed_b(16, 8'h80, 10, 200, acc, stall);
        #2 rst_n = 1'b0;
        #1 check("b_rst_mid_outs", outs_b, 0);
        q_b.delete();
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("b_idle_after_rst", outs_b, 0);
        pulse_start_b();
        feed_b(3, 8'hC0, 0, 50, acc, stall);
        check("b_acc3", 32'(acc), 3);
        pulse_end_b();
        wait_done_b(100);
        repeat (2) @(negedge clk);
        check("b_q_empty_rst", 32'(q_b.size()), 0);
        check("b_short_after3", 32'(short_b), 1);

        // A1: full image, valid held high, FIFO fills and ready drops
        pulse_start_a();
        n0 = ndone_a;
        feed_a(8, 8'h10, -1, 200, acc, stall);
        check("a1_acc", 32'(acc), 8);
        check("a1_ready_drop", 32'(stall > 0), 1);
        wait_done_a(200);
        repeat (3) @(negedge clk);
        check("a1_done_once", 32'(ndone_a - n0), 1);
        check("a1_done_lat", 32'(done_cyc_a - last_wr_a), 4);
        check("a1_short", 32'(short_a), 0);
        check("a1_q_empty", 32'(q_a.size()), 0);

        // A2: short image ended by dl_end
        pulse_start_a();
        n0 = ndone_a;
        feed_a(5, 8'h20, -1, 100, acc, stall);
        check("a2_acc", 32'(acc), 5);
        pulse_end_a();
        wait_done_a(200);
        repeat (10) @(negedge clk);
        check("a2_done_once", 32'(ndone_a - n0), 1);
        check("a2_short_sticky", 32'(short_a), 1);
        check("a2_q_empty", 32'(q_a.size()), 0);

        // A3: host offers 12 bytes, only 8 taken
        pulse_start_a();
        feed_a(12, 8'h30, -1, 24, acc, stall);
        check("a3_acc", 32'(acc), 8);
        check("a3_ready_low", 32'(ready_a), 0);
        wait_done_a(200);
        repeat (3) @(negedge clk);
        check("a3_short", 32'(short_a), 0);
        check("a3_q_empty", 32'(q_a.size()), 0);

        // A4: dl_start during LOAD ignored, then restart after DONE
        pulse_start_a();
        n0 = ndone_a;
        feed_a(8, 8'h50, 3, 200, acc, stall);
        check("a4_acc", 32'(acc), 8);
        wait_done_a(200);
        repeat (3) @(negedge clk);
        check("a4_done_once", 32'(ndone_a - n0), 1);
        check("a4_q_empty", 32'(q_a.size()), 0);
        pulse_start_a();
        feed_a(2, 8'h60, -1, 50, acc, stall);
        pulse_end_a();
        wait_done_a(200);
        repeat (3) @(negedge clk);
        check("a4_restart_q_empty", 32'(q_a.size()), 0);
        check("a4_restart_addr", 32'(addr_a), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
